stack_flow_sequencer: RTL and testbench
=======================================

Name: stack_flow_sequencer

Overview:
Control-flow micro-op sequencer for the five-stage pipeline. It arbitrates CALL, RET and RTI requests from decode, plus external interrupts, and injects the stack micro-op sequence for each into the pipeline while stalling fetch. It then issues a one-cycle PC redirect with the target. It sits between decode and the fetch/PC-select logic and replaces per-instruction ad-hoc FSMs.

Parameters:
PUSH_PC_LOW_OP, 16'h6008, micro-op pushing PC[15:0]
PUSH_PC_HIGH_OP, 16'h6009, micro-op pushing PC[31:16]
PUSH_FLAGS_OP, 16'h600A, micro-op pushing flags
POP_PC_HIGH_OP, 16'h7009, micro-op popping PC[31:16]
POP_PC_LOW_OP, 16'h7008, micro-op popping PC[15:0]
POP_FLAGS_OP, 16'h700A, micro-op popping flags
INT_VECTOR, 32'h0000_0000, interrupt handler address

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-low reset
call  input  1  CALL request, level, held until instr_ack
ret  input  1  RET request, level, held until instr_ack
rti  input  1  RTI request, level, held until instr_ack
rdst_value  input  16  CALL target, valid with call
int_req  input  1  interrupt request pulse
pop_ack  input  1  memory stage returns pop data this cycle
pop_data  input  16  popped word, valid with pop_ack
instr_ack  output  1  1-cycle pulse: instruction request accepted
int_ack  output  1  1-cycle pulse: interrupt accepted
op_out  output  16  injected micro-op; 16'h0000 when op_valid=0
op_valid  output  1  op_out is a real micro-op
stall  output  1  hold fetch/decode
change_pc  output  1  1-cycle PC redirect strobe
pc_target  output  32  redirect address, valid with change_pc
flags_restore  output  1  1-cycle strobe: load flags_value into flags
flags_value  output  16  popped flags

Behaviour:
- States: IDLE, PUSH_LO, PUSH_HI, PUSH_FL, POP_FL, POP_HI, POP_LO, LOAD_PC. State and all outputs are registered. There is no combinational input-to-output path.
- Reset (reset=0, async): state=IDLE, int_pending=0, target/flags regs=0, all outputs 0.
- int_pending is set on any int_req=1 not accepted in that same cycle, and is cleared when the interrupt is accepted. Repeated int_req while pending has no further effect.
- IDLE arbitration, evaluated at each edge, highest priority first:
  1. int_pending or int_req: go to PUSH_LO; int_ack=1 next cycle; target=INT_VECTOR.
  2. call: go to PUSH_LO; instr_ack=1 next cycle; target={16'h0,rdst_value}.
  3. ret: go to POP_HI; instr_ack=1.
  4. rti: go to POP_FL; instr_ack=1.
- A losing instruction request stays high, because decode holds it, and is served in a later IDLE cycle.
- Sequences:
  - CALL: PUSH_LO, PUSH_HI, LOAD_PC, IDLE.
  - Interrupt: PUSH_LO, PUSH_HI, PUSH_FL, LOAD_PC, IDLE.
  - RET: POP_HI, POP_LO, LOAD_PC, IDLE.
  - RTI: POP_FL, POP_HI, POP_LO, LOAD_PC, IDLE.
- PUSH_* states last exactly 1 cycle each. op_valid=1 and op_out is the matching push opcode.
- POP_* states present the matching pop opcode with op_valid=1 and hold until pop_ack=1. On the ack edge:
  - POP_FL captures flags_value and pulses flags_restore for the next cycle.
  - POP_HI captures target[31:16].
  - POP_LO captures target[15:0].
  - Each then advances to the next state.
- pop_ack outside POP_* states is ignored.
- LOAD_PC: op_valid=0, op_out=0, change_pc=1, pc_target=target.
- stall=1 in every non-IDLE state, including LOAD_PC. stall=0 in IDLE.
- Latency from request edge: CALL stall is 3 cycles; interrupt stall is 4 cycles; RET/RTI stall is 3 or 4 cycles plus pop wait cycles.
- An interrupt arriving during a CALL sequence is latched. It starts on the first IDLE edge after the sequence, giving one IDLE cycle with stall=0 in between.
- Reset asserted mid-sequence aborts it immediately. No change_pc is issued and the pending interrupt is lost.

Test Plan:
- CALL with rdst_value=16'h1234 in IDLE -> op_out is 6008, then 6009 with stall=1, then change_pc=1 with pc_target=32'h0000_1234; instr_ack pulses once; stall drops on the 4th cycle.
- RET with pop_ack delayed 2 cycles on POP_HI (pop_data=16'h0001), then immediate ack on POP_LO (16'h0040) -> 7009 is held for 3 cycles, then 7008, then pc_target=32'h0001_0040.
- RTI with pops 16'h0005, 16'h0000, 16'h0200 -> flags_restore=1 with flags_value=16'h0005, then change_pc with pc_target=32'h0000_0200.
- int_req and call high in the same IDLE cycle -> interrupt sequence (6008, 6009, 600A, pc_target=INT_VECTOR) runs first; call stays high and is then accepted with instr_ack.
- int_req pulsed twice during a CALL sequence -> exactly one interrupt sequence follows and int_ack pulses once.
- Reset pulsed low during POP_HI -> all outputs are 0 asynchronously; after release, state is IDLE and a late pop_ack is ignored.

Source files
------------

// File: rtl/stack_flow_sequencer.sv
// Control-flow micro-op sequencer: arbitrates CALL/RET/RTI and interrupts, injects
// stack push/pop micro-ops while stalling fetch, then issues a one-cycle PC redirect.
module stack_flow_sequencer #(
    parameter logic [15:0] PUSH_PC_LOW_OP  = 16'h6008,
    parameter logic [15:0] PUSH_PC_HIGH_OP = 16'h6009,
    parameter logic [15:0] PUSH_FLAGS_OP   = 16'h600A,
    parameter logic [15:0] POP_PC_HIGH_OP  = 16'h7009,
    parameter logic [15:0] POP_PC_LOW_OP   = 16'h7008,
    parameter logic [15:0] POP_FLAGS_OP    = 16'h700A,
    parameter logic [31:0] INT_VECTOR      = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        reset_ni,
    input  logic        call_i,
    input  logic        ret_i,
    input  logic        rti_i,
    input  logic [15:0] rdst_value_i,
    input  logic        int_req_i,
    input  logic        pop_ack_i,
    input  logic [15:0] pop_data_i,
    output logic        instr_ack_o,
    output logic        int_ack_o,
    output logic [15:0] op_out_o,
    output logic        op_valid_o,
    output logic        stall_o,
    output logic        change_pc_o,
    output logic [31:0] pc_target_o,
    output logic        flags_restore_o,
    output logic [15:0] flags_value_o
);

    typedef enum logic [2:0] {
        S_IDLE, S_PUSH_LO, S_PUSH_HI, S_PUSH_FL,
        S_POP_FL, S_POP_HI, S_POP_LO, S_LOAD_PC
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] target_q, target_d;
    logic [15:0] flags_q, flags_d;
    logic        int_pending_q, int_pending_d;
    logic        seq_int_q, seq_int_d;
    logic        instr_ack_d, int_ack_d, flags_restore_d;
    logic [15:0] op_d;
    logic        op_valid_d, stall_d, change_pc_d;
    logic [31:0] pc_target_d;
    logic        accept_int;

    always_comb begin
        state_d         = state_q;
        target_d        = target_q;
        flags_d         = flags_q;
        seq_int_d       = seq_int_q;
        instr_ack_d     = 1'b0;
        int_ack_d       = 1'b0;
        flags_restore_d = 1'b0;
        accept_int      = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (int_pending_q || int_req_i) begin
                    state_d    = S_PUSH_LO;
                    int_ack_d  = 1'b1;
                    target_d   = INT_VECTOR;
                    seq_int_d  = 1'b1;
                    accept_int = 1'b1;
                end else if (call_i) begin
                    state_d     = S_PUSH_LO;
                    instr_ack_d = 1'b1;
                    target_d    = {16'h0000, rdst_value_i};
                    seq_int_d   = 1'b0;
                end else if (ret_i) begin
                    state_d     = S_POP_HI;
                    instr_ack_d = 1'b1;
                end else if (rti_i) begin
                    state_d     = S_POP_FL;
                    instr_ack_d = 1'b1;
                end
            end
            S_PUSH_LO: state_d = S_PUSH_HI;
            // Only the interrupt sequence saves flags before redirecting.
            S_PUSH_HI: state_d = seq_int_q ? S_PUSH_FL : S_LOAD_PC;
            S_PUSH_FL: state_d = S_LOAD_PC;
            S_POP_FL: begin
                if (pop_ack_i) begin
                    flags_d         = pop_data_i;
                    flags_restore_d = 1'b1;
                    state_d         = S_POP_HI;
                end
            end
            S_POP_HI: begin
                if (pop_ack_i) begin
                    target_d[31:16] = pop_data_i;
                    state_d         = S_POP_LO;
                end
            end
            S_POP_LO: begin
                if (pop_ack_i) begin
                    target_d[15:0] = pop_data_i;
                    state_d        = S_LOAD_PC;
                end
            end
            S_LOAD_PC: state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase

        if (accept_int)
            int_pending_d = 1'b0;
        else if (int_req_i)
            int_pending_d = 1'b1;
        else
            int_pending_d = int_pending_q;

        // Outputs are decoded from the next state so they appear registered with it.
        unique case (state_d)
            S_PUSH_LO: op_d = PUSH_PC_LOW_OP;
            S_PUSH_HI: op_d = PUSH_PC_HIGH_OP;
            S_PUSH_FL: op_d = PUSH_FLAGS_OP;
            S_POP_FL:  op_d = POP_FLAGS_OP;
            S_POP_HI:  op_d = POP_PC_HIGH_OP;
            S_POP_LO:  op_d = POP_PC_LOW_OP;
            default:   op_d = 16'h0000;
        endcase
        op_valid_d  = (state_d != S_IDLE) && (state_d != S_LOAD_PC);
        stall_d     = (state_d != S_IDLE);
        change_pc_d = (state_d == S_LOAD_PC);
        pc_target_d = (state_d == S_LOAD_PC) ? target_d : 32'h0000_0000;
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q         <= S_IDLE;
            target_q        <= 32'h0000_0000;
            flags_q         <= 16'h0000;
            int_pending_q   <= 1'b0;
            seq_int_q       <= 1'b0;
            instr_ack_o     <= 1'b0;
            int_ack_o       <= 1'b0;
            op_out_o        <= 16'h0000;
            op_valid_o      <= 1'b0;
            stall_o         <= 1'b0;
            change_pc_o     <= 1'b0;
            pc_target_o     <= 32'h0000_0000;
            flags_restore_o <= 1'b0;
        end else begin
            state_q         <= state_d;
            target_q        <= target_d;
            flags_q         <= flags_d;
            int_pending_q   <= int_pending_d;
            seq_int_q       <= seq_int_d;
            instr_ack_o     <= instr_ack_d;
            int_ack_o       <= int_ack_d;
            op_out_o        <= op_d;
            op_valid_o      <= op_valid_d;
            stall_o         <= stall_d;
            change_pc_o     <= change_pc_d;
            pc_target_o     <= pc_target_d;
            flags_restore_o <= flags_restore_d;
        end
    end

    assign flags_value_o = flags_q;

endmodule

// File: tb/tb_stack_flow_sequencer.sv
// Directed plus randomized bench for stack_flow_sequencer, checked every cycle
// against a queue-based reference model of the micro-op sequences.
module tb_stack_flow_sequencer;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        in_call, in_ret, in_rti, in_int_req, in_pop_ack;
    logic [15:0] in_rdst, in_pop_data;
    logic        instr_ack, int_ack, op_valid, stall, change_pc, flags_restore;
    logic [15:0] op_out, flags_value;
    logic [31:0] pc_target;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    stack_flow_sequencer dut (
        .clk_i           (clk),
        .reset_ni        (reset_n),
        .call_i          (in_call),
        .ret_i           (in_ret),
        .rti_i           (in_rti),
        .rdst_value_i    (in_rdst),
        .int_req_i       (in_int_req),
        .pop_ack_i       (in_pop_ack),
        .pop_data_i      (in_pop_data),
        .instr_ack_o     (instr_ack),
        .int_ack_o       (int_ack),
        .op_out_o        (op_out),
        .op_valid_o      (op_valid),
        .stall_o         (stall),
        .change_pc_o     (change_pc),
        .pc_target_o     (pc_target),
        .flags_restore_o (flags_restore),
        .flags_value_o   (flags_value)
    );

    // Reference model: remaining micro-ops of the active sequence; 0 stands for the redirect.
    logic [15:0] m_seq[$];
    bit          m_pending;
    logic [31:0] m_tgt;
    logic [15:0] m_flv;
    bit          m_iack, m_intack, m_frest;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_seq.delete();
        m_pending = 0;
        m_tgt     = '0;
        m_flv     = '0;
        m_iack    = 0;
        m_intack  = 0;
        m_frest   = 0;
    endtask

    task automatic model_step();
        logic [15:0] cur;
        m_iack   = 0;
        m_intack = 0;
        m_frest  = 0;
        if (m_seq.size() == 0) begin
            if (m_pending || in_int_req) begin
                m_seq.push_back(16'h6008); m_seq.push_back(16'h6009);
                m_seq.push_back(16'h600A); m_seq.push_back(16'h0000);
                m_tgt = 32'h0000_0000; m_intack = 1; m_pending = 0;
            end else if (in_call) begin
                m_seq.push_back(16'h6008); m_seq.push_back(16'h6009);
                m_seq.push_back(16'h0000);
                m_tgt = {16'h0000, in_rdst}; m_iack = 1;
            end else if (in_ret) begin
                m_seq.push_back(16'h7009); m_seq.push_back(16'h7008);
                m_seq.push_back(16'h0000);
                m_iack = 1;
            end else if (in_rti) begin
                m_seq.push_back(16'h700A); m_seq.push_back(16'h7009);
                m_seq.push_back(16'h7008); m_seq.push_back(16'h0000);
                m_iack = 1;
            end
        end else begin
            cur = m_seq[0];
            if (cur[15:12] == 4'h7) begin
                if (in_pop_ack) begin
                    if (cur == 16'h700A) begin
                        m_flv = in_pop_data; m_frest = 1;
                    end else if (cur == 16'h7009) begin
                        m_tgt[31:16] = in_pop_data;
                    end else begin
                        m_tgt[15:0] = in_pop_data;
                    end
                    void'(m_seq.pop_front());
                end
            end else begin
                void'(m_seq.pop_front());
            end
            if (in_int_req) m_pending = 1;
        end
    endtask

    task automatic compare_all();
        bit          busy;
        logic [15:0] head;
        busy = (m_seq.size() != 0);
        head = busy ? m_seq[0] : 16'h0000;
        check_eq("op_out", {16'h0, op_out}, {16'h0, head});
        check_eq("op_valid", {31'h0, op_valid}, {31'h0, busy && head != 16'h0});
        check_eq("stall", {31'h0, stall}, {31'h0, busy});
        check_eq("change_pc", {31'h0, change_pc}, {31'h0, busy && head == 16'h0});
        check_eq("pc_target", pc_target, (busy && head == 16'h0) ? m_tgt : 32'h0);
        check_eq("instr_ack", {31'h0, instr_ack}, {31'h0, m_iack});
        check_eq("int_ack", {31'h0, int_ack}, {31'h0, m_intack});
        check_eq("flags_restore", {31'h0, flags_restore}, {31'h0, m_frest});
        check_eq("flags_value", {16'h0, flags_value}, {16'h0, m_flv});
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        compare_all();
    endtask

    task automatic clear_inputs();
        in_call = 0; in_ret = 0; in_rti = 0; in_int_req = 0;
        in_pop_ack = 0; in_rdst = '0; in_pop_data = '0;
    endtask

    initial begin
        logic [2:0] req;
        int         ack_count;
        clear_inputs();
        model_reset();
        reset_n = 0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("reset_stall", {31'h0, stall}, 32'h0);
        check_eq("reset_op_out", {16'h0, op_out}, 32'h0);
        check_eq("reset_pc_target", pc_target, 32'h0);
        @(negedge clk);
        reset_n = 1;

        // CALL 0x1234
        in_call = 1; in_rdst = 16'h1234;
        tick(); check_eq("call_op0", {16'h0, op_out}, 32'h6008);
        in_call = 0;
        tick(); check_eq("call_op1", {16'h0, op_out}, 32'h6009);
        tick(); check_eq("call_target", pc_target, 32'h0000_1234);
        tick(); check_eq("call_stall_drop", {31'h0, stall}, 32'h0);

        // RET with delayed ack on the high pop
        in_ret = 1;
        tick(); in_ret = 0;
        tick(); tick();
        check_eq("ret_hold_hi", {16'h0, op_out}, 32'h7009);
        in_pop_ack = 1; in_pop_data = 16'h0001;
        tick(); check_eq("ret_op_lo", {16'h0, op_out}, 32'h7008);
        in_pop_data = 16'h0040;
        tick(); check_eq("ret_target", pc_target, 32'h0001_0040);
        in_pop_ack = 0;
        tick();

        // RTI restores flags then redirects
        in_rti = 1;
        tick(); in_rti = 0;
        in_pop_ack = 1; in_pop_data = 16'h0005;
        tick(); check_eq("rti_flags_restore", {31'h0, flags_restore}, 32'h1);
        check_eq("rti_flags_value", {16'h0, flags_value}, 32'h0005);
        in_pop_data = 16'h0000;
        tick(); in_pop_data = 16'h0200;
        tick(); check_eq("rti_target", pc_target, 32'h0000_0200);
        in_pop_ack = 0;
        tick();

        // Interrupt wins over a simultaneous CALL; CALL served afterwards
        in_int_req = 1; in_call = 1; in_rdst = 16'h0055;
        tick(); check_eq("int_first_ack", {31'h0, int_ack}, 32'h1);
        in_int_req = 0;
        tick(); tick(); check_eq("int_flags_push", {16'h0, op_out}, 32'h600A);
        tick(); check_eq("int_target", pc_target, 32'h0);
        tick(); tick(); check_eq("late_call_ack", {31'h0, instr_ack}, 32'h1);
        in_call = 0;
        repeat (3) tick();

        // Two interrupt pulses during a CALL yield a single interrupt sequence
        in_call = 1; in_rdst = 16'h0777;
        tick(); in_call = 0; in_int_req = 1;
        tick(); in_int_req = 0;
        tick(); in_int_req = 1;
        ack_count = 0;
        tick(); in_int_req = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (int_ack) ack_count++;
        end
        check_eq("single_int_ack", ack_count, 1);

        // Asynchronous reset during POP_HI, then a stray pop_ack
        in_ret = 1;
        tick(); in_ret = 0; in_int_req = 1;
        tick(); in_int_req = 0;
        #3 reset_n = 0;
        #1;
        check_eq("async_rst_stall", {31'h0, stall}, 32'h0);
        check_eq("async_rst_op_valid", {31'h0, op_valid}, 32'h0);
        check_eq("async_rst_op_out", {16'h0, op_out}, 32'h0);
        check_eq("async_rst_ack", {31'h0, instr_ack}, 32'h0);
        model_reset();
        #2 reset_n = 1;
        in_pop_ack = 1; in_pop_data = 16'hBEEF;
        tick(); check_eq("stray_ack_idle", {31'h0, stall}, 32'h0);
        in_pop_ack = 0;
        tick();

        // Randomized traffic with decode-style held requests
        req = 3'b000;
        for (int c = 0; c < 3000; c++) begin
            tick();
            if (m_iack) begin
                if (req[0])      req[0] = 1'b0;
                else if (req[1]) req[1] = 1'b0;
                else             req[2] = 1'b0;
            end
            if (req == 3'b000 && $urandom_range(0, 5) == 0) begin
                req     = 3'($urandom_range(1, 7));
                in_rdst = 16'($urandom);
            end
            in_call     = req[0];
            in_ret      = req[1];
            in_rti      = req[2];
            in_int_req  = ($urandom_range(0, 14) == 0);
            in_pop_ack  = $urandom_range(0, 1) == 1;
            in_pop_data = 16'($urandom);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
